// File: rtl/tspi_shift_engine.sv
// tspi serial shift stage: runs the baud generator for one word, drives MOSI/CS, samples MISO (mode 0).
// Optional feature macro: TSPI_SHIFT_LOOPBACK_EN adds loopback_i (serial input taken from mosi_o).
module tspi_shift_engine #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_i,
  output logic                 run_o,
  output logic                 new_req_o,
  input  logic                 msb_first_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 sck_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
`ifdef TSPI_SHIFT_LOOPBACK_EN
  input  logic                 loopback_i,
`endif
  output logic                 cs_no,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(DataWidth + 1);
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] LastCnt = CntW'(DataWidth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  state_e                state_r;
  state_e                state_nxt_s;
  logic                  baud_q_r;
  logic                  rise_s;
  logic                  fall_s;
  logic                  xfer_s;
  logic                  ser_in_s;
  logic [DataWidth-1:0]  tx_sh_r;
  logic [DataWidth-1:0]  rx_sh_r;
  logic [CntW-1:0]       bit_cnt_r;
  logic                  msb_r;
  logic                  run_r;
  logic                  new_req_r;
  logic                  busy_r;
  logic                  cs_n_r;
  logic                  mosi_r;
  logic [DataWidth-1:0]  rx_data_r;
  logic                  rx_valid_r;
  logic                  rdy_en_r;

  assign rise_s = ~baud_q_r & baud_i;
  assign fall_s = baud_q_r & ~baud_i;

  // The rx slot must be free (or being taken now) before a new word may start.
  assign tx_ready_o = (state_r == ST_IDLE) & rdy_en_r & (~rx_valid_r | rx_ready_i);
  assign xfer_s     = tx_valid_i & tx_ready_o;

`ifdef TSPI_SHIFT_LOOPBACK_EN
  logic loop_r;

  // Loopback select is frozen at START for the whole word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loop_r <= 1'b0;
    end else if (state_r == ST_START) begin
      loop_r <= loopback_i;
    end
  end

  assign ser_in_s = loop_r ? mosi_r : miso_i;
`else
  assign ser_in_s = miso_i;
`endif

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fall_s && (bit_cnt_r == LastCnt)) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_FINISH: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and baud edge-detect delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      baud_q_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      baud_q_r <= baud_i;
    end
  end

  // Control outputs are flopped from the next state so they align with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_r     <= 1'b0;
      new_req_r <= 1'b0;
      busy_r    <= 1'b0;
      rdy_en_r  <= 1'b0;
    end else begin
      run_r     <= (state_nxt_s == ST_START) || (state_nxt_s == ST_SHIFT);
      new_req_r <= (state_nxt_s == ST_START);
      busy_r    <= (state_nxt_s != ST_IDLE);
      rdy_en_r  <= 1'b1;
    end
  end

  // Shift datapath: load at accept, sample on rising SCK, advance MOSI on falling SCK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_sh_r   <= {DataWidth{1'b0}};
      rx_sh_r   <= {DataWidth{1'b0}};
      bit_cnt_r <= CntZero;
      msb_r     <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            tx_sh_r   <= tx_data_i;
            msb_r     <= msb_first_i;
            bit_cnt_r <= CntZero;
            cs_n_r    <= 1'b0;
            mosi_r    <= msb_first_i ? tx_data_i[DataWidth-1] : tx_data_i[0];
          end
        end
        ST_SHIFT: begin
          if (rise_s) begin
            rx_sh_r   <= msb_r ? {rx_sh_r[DataWidth-2:0], ser_in_s}
                               : {ser_in_s, rx_sh_r[DataWidth-1:1]};
            bit_cnt_r <= bit_cnt_r + CntOne;
          end else if (fall_s && (bit_cnt_r != LastCnt)) begin
            tx_sh_r <= msb_r ? {tx_sh_r[DataWidth-2:0], 1'b0}
                             : {1'b0, tx_sh_r[DataWidth-1:1]};
            mosi_r  <= msb_r ? tx_sh_r[DataWidth-2] : tx_sh_r[1];
          end
        end
        ST_FINISH: begin
          cs_n_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Received-word holding slot; a load in FINISH wins over a simultaneous take.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_r  <= {DataWidth{1'b0}};
      rx_valid_r <= 1'b0;
    end else if (state_r == ST_FINISH) begin
      rx_data_r  <= rx_sh_r;
      rx_valid_r <= 1'b1;
    end else if (rx_valid_r && rx_ready_i) begin
      rx_valid_r <= 1'b0;
    end
  end

  assign run_o      = run_r;
  assign new_req_o  = new_req_r;
  assign busy_o     = busy_r;
  assign cs_no      = cs_n_r;
  assign mosi_o     = mosi_r;
  assign sck_o      = baud_i & run_r;
  assign rx_data_o  = rx_data_r;
  assign rx_valid_o = rx_valid_r;

endmodule

// File: tb/tb_tspi_shift_engine.sv
// Directed bench for tspi_shift_engine with a small baud-generator model; optional loopback test
// when TSPI_SHIFT_LOOPBACK_EN is defined.
module tb_tspi_shift_engine;

  localparam int Half = 2;

  logic       clk;
  logic       rst_n;
  logic       baud;
  logic       run;
  logic       new_req;
  logic       msb_first;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;
  logic       busy;
`ifdef TSPI_SHIFT_LOOPBACK_EN
  logic       loopback;
`endif

  int checks = 0;
  int errors = 0;
  int bcnt;

  tspi_shift_engine #(.DataWidth(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .baud_i     (baud),
    .run_o      (run),
    .new_req_o  (new_req),
    .msb_first_i(msb_first),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .sck_o      (sck),
    .mosi_o     (mosi),
    .miso_i     (miso),
`ifdef TSPI_SHIFT_LOOPBACK_EN
    .loopback_i (loopback),
`endif
    .cs_no      (cs_n),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud generator model: new_req forces level high, run toggles every Half cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud <= 1'b0;
      bcnt <= 0;
    end else if (new_req) begin
      baud <= 1'b1;
      bcnt <= 0;
    end else if (run) begin
      if (bcnt == Half - 1) begin
        baud <= ~baud;
        bcnt <= 0;
      end else begin
        bcnt <= bcnt + 1;
      end
    end else begin
      baud <= 1'b0;
      bcnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word; sw is the slave's MISO word, abort_rises>0 stops after that many SCK rises.
  task automatic xfer(input logic [7:0] tx, input logic msb, input logic [7:0] sw,
                      input logic take, input int abort_rises,
                      output logic [7:0] mcap, output int nreq, output int rises,
                      output logic first_bit);
    int   idx;
    logic prev_sck;
    logic prev_fin;
    logic got;
    logic done;
    idx       = 0;
    miso      = msb ? sw[7] : sw[0];
    tx_data   = tx;
    msb_first = msb;
    tx_valid  = 1'b1;
    rx_ready  = take;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (tx_ready) begin
        got = 1'b1;
        chk("cs_high_before_word", {31'd0, cs_n}, 32'd1);
      end
      step();
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    chk("word_accepted", {31'd0, got}, 32'd1);
    if (take) chk("rx_taken_at_accept", {31'd0, rx_valid}, 32'd0);
    mcap      = 8'h00;
    nreq      = 0;
    rises     = 0;
    first_bit = 1'b0;
    prev_sck  = 1'b0;
    prev_fin  = 1'b0;
    done      = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (new_req) nreq++;
      if (sck && !prev_sck) begin
        rises++;
        mcap = msb ? {mcap[6:0], mosi} : {mosi, mcap[7:1]};
        if (rises == 1) begin
          first_bit = mosi;
          chk("cs_low_in_word", {31'd0, cs_n}, 32'd0);
        end
      end
      if (!sck && prev_sck) begin
        idx++;
        if (idx < 8) miso = msb ? sw[7 - idx] : sw[idx];
      end
      if (abort_rises > 0 && rises == abort_rises) begin
        done = 1'b1;
      end else if (rx_valid) begin
        done = 1'b1;
        chk("valid_after_finish", {31'd0, prev_fin}, 32'd1);
        chk("cs_high_after_word", {31'd0, cs_n}, 32'd1);
      end else begin
        prev_fin = busy & ~run;
        prev_sck = sck;
        step();
      end
    end
    chk("word_completed", {31'd0, done}, 32'd1);
  endtask

  task automatic take_rx();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("rx_valid_cleared", {31'd0, rx_valid}, 32'd0);
  endtask

  logic [7:0] mcap;
  int         nreq;
  int         rises;
  logic       fb;

  initial begin
    rst_n     = 1'b0;
    msb_first = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    miso      = 1'b0;
`ifdef TSPI_SHIFT_LOOPBACK_EN
    loopback  = 1'b0;
`endif
    #12;
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_new_req", {31'd0, new_req}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("idle_cs_n", {31'd0, cs_n}, 32'd1);
    chk("idle_run", {31'd0, run}, 32'd0);
    chk("idle_sck", {31'd0, sck}, 32'd0);
    chk("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("idle_rx_valid", {31'd0, rx_valid}, 32'd0);

    // MSB-first 0xA5 out, 0x3C in.
    xfer(8'hA5, 1'b1, 8'h3C, 1'b0, 0, mcap, nreq, rises, fb);
    chk("a5_mosi_word", {24'd0, mcap}, 32'hA5);
    chk("a5_rises", rises, 32'd8);
    chk("a5_new_req_pulses", nreq, 32'd1);
    chk("a5_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("a5_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_mosi_holds", {31'd0, mosi}, 32'd1);
    take_rx();

    // LSB-first 0x01 out, MISO stuck at 1.
    xfer(8'h01, 1'b0, 8'hFF, 1'b0, 0, mcap, nreq, rises, fb);
    chk("lsb_first_bit", {31'd0, fb}, 32'd1);
    chk("lsb_mosi_word", {24'd0, mcap}, 32'h01);
    chk("lsb_rx_data", {24'd0, rx_data}, 32'hFF);
    take_rx();

    // Back-to-back 0x11 / 0x22 held off by an untaken rx word.
    xfer(8'h11, 1'b1, 8'h81, 1'b0, 0, mcap, nreq, rises, fb);
    chk("b2b1_rx_data", {24'd0, rx_data}, 32'h81);
    tx_data  = 8'h22;
    tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("b2b_hold_ready", {31'd0, tx_ready}, 32'd0);
    chk("b2b_hold_busy", {31'd0, busy}, 32'd0);
    chk("b2b_hold_rx_valid", {31'd0, rx_valid}, 32'd1);
    xfer(8'h22, 1'b1, 8'h42, 1'b1, 0, mcap, nreq, rises, fb);
    chk("b2b2_mosi_word", {24'd0, mcap}, 32'h22);
    chk("b2b2_rx_data", {24'd0, rx_data}, 32'h42);
    take_rx();

    // Reset after the 4th rising edge of a 0xF0 word.
    xfer(8'hF0, 1'b1, 8'hAA, 1'b0, 4, mcap, nreq, rises, fb);
    chk("abort_rises", rises, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
    chk("abort_run", {31'd0, run}, 32'd0);
    chk("abort_sck", {31'd0, sck}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("abort_no_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("abort_rx_data", {24'd0, rx_data}, 32'h00);
    xfer(8'h5A, 1'b1, 8'h96, 1'b0, 0, mcap, nreq, rises, fb);
    chk("post_abort_mosi", {24'd0, mcap}, 32'h5A);
    chk("post_abort_rx", {24'd0, rx_data}, 32'h96);
    take_rx();

`ifdef TSPI_SHIFT_LOOPBACK_EN
    loopback = 1'b1;
    xfer(8'hC3, 1'b1, 8'h00, 1'b0, 0, mcap, nreq, rises, fb);
    chk("loopback_rx", {24'd0, rx_data}, 32'hC3);
    take_rx();
    loopback = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
